// File: rtl/register_file.sv
// Dual-read, single-write register file with registered read data, write-first
// bypass, optional hardwired-zero register 0 and a stall (Hold) input.
module register_file #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  input  logic              Hold,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout1;
  logic [DATA_W-1:0] r_dout2;

  logic              w_zero_r0;
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_zero_r0 = (ZERO_R0 != 0);

  // A write to r0 is dropped when r0 is hardwired, so it must not bypass either.
  assign w_wr_ok = WrEn && !(w_zero_r0 && (Awr == '0));

  always_comb begin
    w_rd1 = r_mem[Ard1];
    if (w_zero_r0 && (Ard1 == '0)) begin
      w_rd1 = '0;
    end else if (w_wr_ok && (Awr == Ard1)) begin
      w_rd1 = Din;
    end
  end

  always_comb begin
    w_rd2 = r_mem[Ard2];
    if (w_zero_r0 && (Ard2 == '0)) begin
      w_rd2 = '0;
    end else if (w_wr_ok && (Awr == Ard2)) begin
      w_rd2 = Din;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[Awr] <= Din;
    end
  end

  // Hold freezes only the outputs; the array keeps accepting writes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_dout1 <= '0;
      r_dout2 <= '0;
    end else if (!Hold) begin
      r_dout1 <= w_rd1;
      r_dout2 <= w_rd2;
    end
  end

  assign Dout1 = r_dout1;
  assign Dout2 = r_dout2;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one instance with r0 hardwired to zero and
// one with an ordinary r0, both fed from the same stimulus.
module tb_register_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              Clk;
  logic              Rst;
  logic [ADDR_W-1:0] Ard1;
  logic [ADDR_W-1:0] Ard2;
  logic              Hold;
  logic [ADDR_W-1:0] Awr;
  logic [DATA_W-1:0] Din;
  logic              WrEn;
  logic [DATA_W-1:0] Dout1;
  logic [DATA_W-1:0] Dout2;
  logic [DATA_W-1:0] nz_dout1;
  logic [DATA_W-1:0] nz_dout2;

  int n_tests;
  int n_fail;

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1)) dut (
    .Clk(Clk), .Rst(Rst), .Ard1(Ard1), .Ard2(Ard2), .Hold(Hold),
    .Awr(Awr), .Din(Din), .WrEn(WrEn), .Dout1(Dout1), .Dout2(Dout2)
  );

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(0)) dut_nz (
    .Clk(Clk), .Rst(Rst), .Ard1(Ard1), .Ard2(Ard2), .Hold(Hold),
    .Awr(Awr), .Din(Din), .WrEn(WrEn), .Dout1(nz_dout1), .Dout2(nz_dout2)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rst  = 1'b0;
    Hold = 1'b0;
    WrEn = 1'b0;
    Awr  = '0;
    Din  = '0;
    Ard1 = '0;
    Ard2 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Rst = 1'b1;
    tick();
    n_tests++;
    if (Dout1 !== 32'h0) begin n_fail++; $display("FAIL reset_dout1 got=%h exp=%h", Dout1, 32'h0); end
    n_tests++;
    if (Dout2 !== 32'h0) begin n_fail++; $display("FAIL reset_dout2 got=%h exp=%h", Dout2, 32'h0); end
    Rst  = 1'b0;
    WrEn = 1'b1; Awr = 5'd5; Din = 32'hDEADBEEF;
    tick();
    WrEn = 1'b0; Ard1 = 5'd5;
    tick();
    n_tests++;
    if (Dout1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset_pre_r5 got=%h exp=%h", Dout1, 32'hDEADBEEF); end
    // Reset with a write pending to r6: the write must be discarded.
    Rst = 1'b1; WrEn = 1'b1; Awr = 5'd6; Din = 32'h12345678;
    tick();
    n_tests++;
    if (Dout1 !== 32'h0) begin n_fail++; $display("FAIL reset_during_dout1 got=%h exp=%h", Dout1, 32'h0); end
    Rst = 1'b0; WrEn = 1'b0; Ard1 = 5'd5; Ard2 = 5'd6;
    tick();
    n_tests++;
    if (Dout1 !== 32'h0) begin n_fail++; $display("FAIL reset_cleared_r5 got=%h exp=%h", Dout1, 32'h0); end
    n_tests++;
    if (Dout2 !== 32'h0) begin n_fail++; $display("FAIL reset_write_discarded_r6 got=%h exp=%h", Dout2, 32'h0); end
  endtask

  task automatic test_write_read();
    idle_inputs();
    WrEn = 1'b1; Awr = 5'd3; Din = 32'd2;
    tick();
    WrEn = 1'b1; Awr = 5'd4; Din = 32'd1; Ard1 = 5'd3; Ard2 = 5'd3;
    tick();
    n_tests++;
    if (Dout1 !== 32'd2) begin n_fail++; $display("FAIL wr_rd_dout1 got=%h exp=%h", Dout1, 32'd2); end
    n_tests++;
    if (Dout2 !== 32'd2) begin n_fail++; $display("FAIL wr_rd_dout2 got=%h exp=%h", Dout2, 32'd2); end
    WrEn = 1'b0; Ard1 = 5'd3; Ard2 = 5'd4;
    tick();
    n_tests++;
    if (Dout1 !== 32'd2) begin n_fail++; $display("FAIL wr_rd_pair_a got=%h exp=%h", Dout1, 32'd2); end
    n_tests++;
    if (Dout2 !== 32'd1) begin n_fail++; $display("FAIL wr_rd_pair_b got=%h exp=%h", Dout2, 32'd1); end
  endtask

  task automatic test_r0();
    idle_inputs();
    WrEn = 1'b1; Awr = 5'd0; Din = 32'hFFFFFFFF; Ard1 = 5'd0;
    tick();
    n_tests++;
    if (Dout1 !== 32'h0) begin n_fail++; $display("FAIL r0_same_cycle got=%h exp=%h", Dout1, 32'h0); end
    n_tests++;
    if (nz_dout1 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL r0_nz_bypass got=%h exp=%h", nz_dout1, 32'hFFFFFFFF); end
    WrEn = 1'b0;
    tick();
    n_tests++;
    if (Dout1 !== 32'h0) begin n_fail++; $display("FAIL r0_next_cycle got=%h exp=%h", Dout1, 32'h0); end
    n_tests++;
    if (nz_dout1 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL r0_nz_stored got=%h exp=%h", nz_dout1, 32'hFFFFFFFF); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    WrEn = 1'b1; Awr = 5'd7; Din = 32'h10;
    tick();
    WrEn = 1'b1; Awr = 5'd7; Din = 32'h20; Ard1 = 5'd7; Ard2 = 5'd7;
    tick();
    n_tests++;
    if (Dout2 !== 32'h20) begin n_fail++; $display("FAIL bypass_dout2 got=%h exp=%h", Dout2, 32'h20); end
    n_tests++;
    if (Dout1 !== 32'h20) begin n_fail++; $display("FAIL bypass_dout1 got=%h exp=%h", Dout1, 32'h20); end
    WrEn = 1'b0;
    tick();
    n_tests++;
    if (Dout2 !== 32'h20) begin n_fail++; $display("FAIL bypass_stored got=%h exp=%h", Dout2, 32'h20); end
  endtask

  task automatic test_hold();
    idle_inputs();
    WrEn = 1'b1; Awr = 5'd7; Din = 32'h10;
    tick();
    WrEn = 1'b0; Ard1 = 5'd7;
    tick();
    n_tests++;
    if (Dout1 !== 32'h10) begin n_fail++; $display("FAIL hold_pre got=%h exp=%h", Dout1, 32'h10); end
    Hold = 1'b1; WrEn = 1'b1; Awr = 5'd7; Din = 32'h30;
    tick();
    n_tests++;
    if (Dout1 !== 32'h10) begin n_fail++; $display("FAIL hold_write_cycle got=%h exp=%h", Dout1, 32'h10); end
    WrEn = 1'b0;
    tick();
    n_tests++;
    if (Dout1 !== 32'h10) begin n_fail++; $display("FAIL hold_second_cycle got=%h exp=%h", Dout1, 32'h10); end
    Hold = 1'b0;
    tick();
    n_tests++;
    if (Dout1 !== 32'h30) begin n_fail++; $display("FAIL hold_release got=%h exp=%h", Dout1, 32'h30); end
  endtask

  task automatic test_sweep();
    logic [DATA_W-1:0] exp1;
    logic [DATA_W-1:0] exp2;
    idle_inputs();
    for (int i = 1; i < 32; i++) begin
      WrEn = 1'b1; Awr = i[ADDR_W-1:0]; Din = i * 32'h01010101;
      tick();
    end
    WrEn = 1'b0;
    for (int k = 0; k < 32; k++) begin
      Ard1 = k[ADDR_W-1:0];
      Ard2 = 5'(31 - k);
      tick();
      exp1 = k * 32'h01010101;
      exp2 = (31 - k) * 32'h01010101;
      n_tests++;
      if (Dout1 !== exp1) begin n_fail++; $display("FAIL sweep_p1 addr=%0d got=%h exp=%h", k, Dout1, exp1); end
      n_tests++;
      if (Dout2 !== exp2) begin n_fail++; $display("FAIL sweep_p2 addr=%0d got=%h exp=%h", 31 - k, Dout2, exp2); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_hold();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
